// File: rtl/mult_err_monitor.sv
// mult_err_monitor: windowed error statistics (sum/max error distance, error count) for the approximate multiplier.
// Define MULT_ERR_BIAS_EN to add the signed bias accumulator output sum_err.
module mult_err_monitor #(
    parameter int N_SAMPLES_LOG2 = 10,
    parameter int ACC_W = 48
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic signed [15:0]        x,
    input  logic signed [15:0]        y,
    input  logic signed [31:0]        p_approx,
    output logic                      busy,
    output logic                      done,
    output logic [ACC_W-1:0]          sum_ed,
    output logic [32:0]               max_ed,
    output logic [N_SAMPLES_LOG2:0]   err_cnt,
    output logic [N_SAMPLES_LOG2:0]   sample_cnt
`ifdef MULT_ERR_BIAS_EN
    ,
    output logic signed [ACC_W-1:0]   sum_err
`endif
);
    localparam int CW = N_SAMPLES_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << N_SAMPLES_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic accept, clear, v0, v1;
    logic signed [15:0] x_s0, y_s0;
    logic signed [31:0] exact;
    logic signed [32:0] diff;
    logic [32:0] ed, ed_s1;

    assign accept = state == RUN && in_valid;
    assign clear = state == IDLE && start;
    // p_approx arrives one cycle after its operands, aligned with the S0 registers
    assign exact = 32'(x_s0) * 32'(y_s0);
    assign diff = 33'(exact) - 33'(p_approx);
    assign ed = diff[32] ? -diff : diff;

    always_comb begin
        state_n = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: state_n = start ? RUN : IDLE;
            RUN: begin
                busy = 1'b1;
                state_n = (accept && sample_cnt == LAST) ? DRAIN : RUN;
            end
            DRAIN: begin
                busy = 1'b1;
                state_n = (!v0 && !v1) ? DONE : DRAIN;
            end
            default: begin
                done = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            v0 <= 1'b0;
            v1 <= 1'b0;
            sum_ed <= '0;
            max_ed <= '0;
            err_cnt <= '0;
            sample_cnt <= '0;
        end else begin
            state <= state_n;
            v0 <= accept;
            x_s0 <= x;
            y_s0 <= y;
            v1 <= v0;
            ed_s1 <= ed;
            if (clear) begin
                sum_ed <= '0;
                max_ed <= '0;
                err_cnt <= '0;
                sample_cnt <= '0;
            end else begin
                if (v1) begin
                    sum_ed <= sum_ed + {{(ACC_W-33){1'b0}}, ed_s1};
                    max_ed <= (ed_s1 > max_ed) ? ed_s1 : max_ed;
                    err_cnt <= err_cnt + CW'(|ed_s1);
                end
                if (accept)
                    sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

`ifdef MULT_ERR_BIAS_EN
    logic signed [32:0] diff_s1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_err <= '0;
        end else begin
            diff_s1 <= diff;
            if (clear)
                sum_err <= '0;
            else if (v1)
                sum_err <= sum_err + ACC_W'(diff_s1);
        end
    end
`endif
endmodule

// File: tb/tb_mult_err_monitor.sv
// tb_mult_err_monitor: randomized scoreboard bench for mult_err_monitor with N_SAMPLES_LOG2=2.
// Expected window results are queued by the stimulus side and checked by a monitor on each done pulse.
module tb_mult_err_monitor;
    localparam int N = 2;
    localparam int W = 48;
    localparam int WIN = 1 << N;

    logic clock = 0, reset, start, in_valid;
    logic signed [15:0] x, y;
    logic signed [31:0] p_approx, p_prev;
    logic busy, done;
    logic [W-1:0] sum_ed;
    logic [32:0] max_ed;
    logic [N:0] err_cnt, sample_cnt;
`ifdef MULT_ERR_BIAS_EN
    logic signed [W-1:0] sum_err;
`endif

    mult_err_monitor #(.N_SAMPLES_LOG2(N), .ACC_W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .x(x), .y(y), .p_approx(p_approx), .busy(busy), .done(done),
        .sum_ed(sum_ed), .max_ed(max_ed), .err_cnt(err_cnt), .sample_cnt(sample_cnt)
`ifdef MULT_ERR_BIAS_EN
        , .sum_err(sum_err)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        longint sum, mx, se;
        int ec, sc, cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0, cyc_n = 0, idle_from = 0;
    bit model_run = 0, prev_done = 0;
    longint m_sum, m_max, m_se;
    int m_ec, m_sc;
    logic signed [15:0] vx[4], vy[4];
    logic signed [31:0] vp[4];

    always @(posedge clock) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic clear_model();
        m_sum = 0; m_max = 0; m_se = 0; m_ec = 0; m_sc = 0;
    endtask

    // One clock cycle of stimulus; the reference model decides acceptance from the window rules.
    task automatic step(input bit st, input bit v, input logic signed [15:0] xx, input logic signed [15:0] yy,
                        input logic signed [31:0] pp);
        longint e;
        start = st; in_valid = v; x = xx; y = yy;
        p_approx = p_prev;
        p_prev = pp;
        if (model_run && v) begin
            e = longint'(xx) * longint'(yy) - longint'(pp);
            m_se += e;
            if (e < 0) e = -e;
            m_sum += e;
            if (e > m_max) m_max = e;
            if (e != 0) m_ec++;
            m_sc++;
            if (m_sc == WIN) begin
                model_run = 0;
                q.push_back('{m_sum, m_max, m_se, m_ec, m_sc, cyc_n + 4});
                idle_from = cyc_n + 5;
            end
        end else if (st && !model_run && cyc_n >= idle_from) begin
            model_run = 1;
            clear_model();
        end
        @(posedge clock); #1;
    endtask

    task automatic window(input int gap, input bit st_gap, input int extra);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, vx[i], vy[i], vp[i]);
            for (int g = 0; g < gap; g++) step(st_gap && g == 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < extra; k++) step(0, 1, 16'($urandom), 16'($urandom), $urandom);
        repeat (6) step(0, 0, 0, 0, 0);
        chk("hold_sum_ed", longint'(sum_ed), m_sum);
        chk("hold_sample_cnt", longint'(sample_cnt), WIN);
        chk("idle_busy", longint'(busy), 0);
    endtask

    task automatic set_vec(input int i, input int xx, input int yy, input int pp);
        vx[i] = 16'(xx); vy[i] = 16'(yy); vp[i] = 32'(pp);
    endtask

    task automatic rand_vec(input bit exact_only);
        for (int i = 0; i < 4; i++) begin
            vx[i] = 16'($urandom);
            vy[i] = 16'($urandom);
            case (exact_only ? 0 : $urandom_range(0, 2))
                0: vp[i] = 32'(vx[i]) * 32'(vy[i]);
                1: vp[i] = 32'(vx[i]) * 32'(vy[i]) + 32'($urandom_range(0, 20)) - 32'sd10;
                default: vp[i] = $urandom;
            endcase
        end
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_sum_ed"}, longint'(sum_ed), 0);
        chk({tag, "_max_ed"}, longint'(max_ed), 0);
        chk({tag, "_err_cnt"}, longint'(err_cnt), 0);
        chk({tag, "_sample_cnt"}, longint'(sample_cnt), 0);
`ifdef MULT_ERR_BIAS_EN
        chk({tag, "_sum_err"}, longint'(sum_err), 0);
`endif
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (prev_done) begin
                chk("done_single", longint'(done), 0);
                chk("busy_after_done", longint'(busy), 0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc_n, e.cyc);
                    chk("sum_ed", longint'(sum_ed), e.sum);
                    chk("max_ed", longint'(max_ed), e.mx);
                    chk("err_cnt", longint'(err_cnt), e.ec);
                    chk("sample_cnt", longint'(sample_cnt), e.sc);
`ifdef MULT_ERR_BIAS_EN
                    chk("sum_err", longint'(sum_err), e.se);
`endif
                end
            end
        end
        prev_done <= done && !reset;
    end

    initial begin
        reset = 1; start = 0; in_valid = 0; x = 0; y = 0; p_approx = 0; p_prev = 0;
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        zero_checks("reset");
        reset = 0;
        rand_vec(1);
        window(0, 0, 0);
        set_vec(0, 3, 5, 14); set_vec(1, -2, 7, -14); set_vec(2, 100, -7, -690); set_vec(3, 0, 0, 0);
        window(0, 0, 0);
        set_vec(0, -32768, -32768, 32'h80000000);
        for (int i = 1; i < 4; i++) begin
            vx[i] = 16'($urandom); vy[i] = 16'($urandom); vp[i] = 32'(vx[i]) * 32'(vy[i]);
        end
        window(0, 0, 0);
        rand_vec(0);
        window(2, 1, 2);
        rand_vec(0);
        step(1, 0, 0, 0, 0);
        step(0, 1, vx[0], vy[0], vp[0]);
        step(0, 1, vx[1], vy[1], vp[1]);
        reset = 1;
        model_run = 0; idle_from = 0;
        clear_model();
        step(0, 1, vx[2], vy[2], vp[2]);
        reset = 0;
        zero_checks("abort");
        repeat (6) step(0, 0, 0, 0, 0);
        chk("abort_no_done_pending", q.size(), 0);
        set_vec(0, 3, 5, 14); set_vec(1, -2, 7, -14); set_vec(2, 100, -7, -690); set_vec(3, 0, 0, 0);
        window(0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            rand_vec(0);
            window($urandom_range(0, 2), 1'($urandom), $urandom_range(0, 2));
        end
        repeat (10) step(0, 0, 0, 0, 0);
        chk("pending_done", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
